// File: rtl/axis_data_gen_ctrl.sv
// Run sequencer for the XDMA stream data generator: decodes the config
// registers into bursts of fixed-length AXI-Stream packets of counting words.
module axis_data_gen_ctrl #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    axi_clk,
  input  logic                    axi_rstn,
  input  logic [31:0]             config_reg0,
  input  logic [31:0]             config_reg1,
  input  logic [31:0]             config_reg2,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             pkt_sent
);

  localparam int LANES = DATA_WIDTH / 32;
  localparam int KW    = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, LOAD, STREAM, GAP, FIN
  } state_t;

  state_t state_q, state_d;

  logic                  start_d, pulse_q;
  logic [31:0]           beats_q, beats_d;
  logic [31:0]           count_q, count_d;
  logic [7:0]            gap_q, gap_d;
  logic                  cont_q, cont_d;
  logic [31:0]           w_q, w_d;
  logic [31:0]           beat_q, beat_d;
  logic [7:0]            gcnt_q, gcnt_d;
  logic                  stop_q, stop_d;
  logic [31:0]           pkt_q, pkt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KW-1:0]         keep_q, keep_d;
  logic [31:0]           beats_ld;
  logic                  hs;
  logic                  unused;

  assign unused = ^{config_reg0[31:16], config_reg0[7:3]};

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [31:0] base
  );
    logic [DATA_WIDTH-1:0] p;
    for (int k = 0; k < LANES; k++)
      p[k*32 +: 32] = base + 32'(k);
    return p;
  endfunction

  assign beats_ld = (config_reg1 == '0) ? 32'd1 : config_reg1;
  assign hs       = valid_q & m_axis_tready;

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    count_d = count_q;
    gap_d   = gap_q;
    cont_d  = cont_q;
    w_d     = w_q;
    beat_d  = beat_q;
    gcnt_d  = gcnt_q;
    stop_d  = stop_q;
    pkt_d   = pkt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    keep_d  = keep_q;

    if (busy_q && (config_reg0[2] || !config_reg0[0]))
      stop_d = 1'b1;

    unique case (state_q)
      IDLE, FIN: begin
        if (pulse_q) begin
          state_d = LOAD;
          done_d  = 1'b0;
          pkt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        stop_d  = 1'b0;
        beats_d = beats_ld;
        count_d = config_reg2;
        gap_d   = config_reg0[15:8];
        cont_d  = config_reg0[1];
        w_d     = '0;
        beat_d  = '0;
        data_d  = pattern('0);
        if (config_reg2 == '0 && !config_reg0[1]) begin
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = STREAM;
          valid_d = 1'b1;
          keep_d  = '1;
          last_d  = (beats_ld == 32'd1);
        end
      end
      STREAM: begin
        if (hs) begin
          w_d    = w_q + 32'(LANES);
          data_d = pattern(w_q + 32'(LANES));
          if (last_q) begin
            pkt_d  = pkt_q + 32'd1;
            beat_d = '0;
            if (stop_q || (!cont_q && pkt_q + 32'd1 == count_q)) begin
              state_d = FIN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              valid_d = 1'b0;
              keep_d  = '0;
              last_d  = 1'b0;
            end else if (gap_q != '0) begin
              state_d = GAP;
              gcnt_d  = gap_q - 8'd1;
              valid_d = 1'b0;
              keep_d  = '0;
              last_d  = 1'b0;
            end else begin
              last_d = (beats_q == 32'd1);
            end
          end else begin
            beat_d = beat_q + 32'd1;
            last_d = (beat_q + 32'd1 == beats_q - 32'd1);
          end
        end
      end
      GAP: begin
        if (stop_q) begin
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (gcnt_q == '0) begin
          state_d = STREAM;
          valid_d = 1'b1;
          keep_d  = '1;
          last_d  = (beats_q == 32'd1);
        end else begin
          gcnt_d = gcnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_rstn) begin
      state_q <= IDLE;
      start_d <= 1'b0;
      pulse_q <= 1'b0;
      beats_q <= 32'd1;
      count_q <= '0;
      gap_q   <= '0;
      cont_q  <= 1'b0;
      w_q     <= '0;
      beat_q  <= '0;
      gcnt_q  <= '0;
      stop_q  <= 1'b0;
      pkt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      state_q <= state_d;
      start_d <= config_reg0[0];
      pulse_q <= config_reg0[0] & ~start_d;
      beats_q <= beats_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      cont_q  <= cont_d;
      w_q     <= w_d;
      beat_q  <= beat_d;
      gcnt_q  <= gcnt_d;
      stop_q  <= stop_d;
      pkt_q   <= pkt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_sent      = pkt_q;

endmodule

// File: doc/axis_data_gen_ctrl.md
# axis_data_gen_ctrl

Sequencer for the XDMA card-to-host stream data generator. It decodes the three 32-bit config registers written over AXI-Lite into a run. A run is a burst of fixed-length AXI-Stream packets carrying an incrementing 32-bit word pattern, with optional inter-packet gaps. The block sits between the AXI-Lite config register file and the XDMA H2C/C2H stream port, and reports run status back for readout.

## Interface
Parameters:
- DATA_WIDTH, 64: stream data width in bits; must be a multiple of 32, from 32 to 512.

Ports:
- axi_clk  in  1  single clock for all logic.
- axi_rstn  in  1  reset; synchronous, active-low.
- config_reg0  in  32  control register:
  - [0] start; a rising edge starts a run.
  - [1] continuous; ignore packet count.
  - [2] stop.
  - [15:8] gap cycles.
  - [31:16] reserved.
- config_reg1  in  32  beats per packet; 0 is treated as 1.
- config_reg2  in  32  packets per run; 0 means an empty run.
- m_axis_tdata  out  DATA_WIDTH  pattern data.
- m_axis_tkeep  out  DATA_WIDTH/8  always all-ones while tvalid is high; 0 otherwise.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tlast  out  1  last beat of a packet.
- m_axis_tready  in  1  AXI-Stream ready.
- busy  out  1  run in progress.
- done  out  1  sticky run-complete flag.
- pkt_sent  out  32  packets completed in the current or last run.

## Operation
- States: IDLE, LOAD, STREAM, GAP, DONE.
- Start detect: config_reg0[0] is registered into start_d each cycle. start_pulse = reg0[0] & ~start_d. Edge detection runs in every state; start_pulse is acted on only in IDLE and DONE.
- IDLE or DONE, on start_pulse → LOAD:
  - clear done and pkt_sent;
  - set busy.
- LOAD: latch the run parameters:
  - beats = max(reg1, 1);
  - count = reg2;
  - gap = reg0[15:8];
  - cont = reg0[1];
  - clear word counter W and beat counter.
  - Next state: if count == 0 and cont == 0 → DONE; else → STREAM.
- Config changes after LOAD have no effect on the current run, except the stop bit.
- STREAM:
  - tvalid = 1.
  - Lane k (32-bit slice k) carries W + k.
  - tlast = 1 when beat counter == beats − 1.
  - On a beat handshake (tvalid & tready): W += DATA_WIDTH/32, and the beat counter increments.
- On a tlast handshake:
  - pkt_sent += 1;
  - beat counter clears.
  - Then, in priority order:
    1. stop_pending, or (cont == 0 and pkt_sent + 1 == count) → DONE.
    2. gap > 0 → GAP.
    3. Otherwise stay in STREAM; the next packet starts back-to-back with tvalid held high.
- GAP:
  - tvalid = 0; a counter counts gap cycles.
  - If stop_pending → DONE immediately.
  - Otherwise → STREAM after exactly gap cycles.
- stop_pending:
  - Set while busy on any cycle where reg0[2] == 1 or reg0[0] == 0.
  - Cleared in LOAD.
  - Stop is graceful: once asserted, tvalid is never withdrawn mid-packet; the current packet completes through tlast.
- DONE:
  - busy = 0, done = 1.
  - Holds until start_pulse.
- W is a 32-bit counter that wraps modulo 2^32. pkt_sent wraps modulo 2^32 in continuous mode.
- Reset mid-run:
  - all state returns to IDLE in the next cycle;
  - stream outputs drop immediately with no tlast. Downstream framing is the integrator's responsibility.

## Timing
- Reset values:
  - tvalid, tlast, busy, done = 0;
  - tdata, tkeep, pkt_sent = 0;
  - start_d = 0, so start held high through reset release is seen as a rising edge.
- Start latency:
  - start_pulse is evaluated at edge N, LOAD occupies edge N+1, and tvalid is first high after edge N+2.
  - busy goes high after edge N+1.
- Throughput: one beat per cycle while tready = 1. Back-to-back packets have no idle cycle when gap == 0.
- Gap: exactly gap cycles with tvalid low, counted from the cycle after the tlast handshake.
- Backpressure: tdata, tlast and tkeep stay stable while tvalid & ~tready.
- Completion: done is set on the cycle after the final tlast handshake, and busy clears on that same cycle.
- Empty run (count == 0, cont == 0): done is set 2 cycles after start_pulse, with no tvalid.
- All outputs are registered; there is no combinational path from tready to tvalid.

## Test plan
- DATA_WIDTH = 64, reg1 = 4, reg2 = 2, gap = 0, tready = 1, start 0→1:
  - 8 consecutive beats; lane words 0..15;
  - tlast on beats 4 and 8;
  - done = 1 and pkt_sent = 2 one cycle after beat 8.
- Same config with gap = 3:
  - exactly 3 tvalid-low cycles between beat 4 and beat 5;
  - beat 5 lane0 = 8.
- reg1 = 3, reg2 = 1, tready toggling 1,0,0,1,0,1:
  - tdata is held during every stall;
  - 3 beats with words 0,2,4 on lane0; tlast on the third.
- cont = 1, reg1 = 2, stop bit set mid-beat-1 of packet 5:
  - packet 5 completes with tlast;
  - then DONE with pkt_sent = 5;
  - tvalid never drops before tlast.
- reg2 = 0, start edge:
  - no tvalid;
  - done = 1 two cycles after start; busy high for 1 cycle.
- axi_rstn low during beat 2 of a 4-beat packet:
  - next cycle tvalid = 0, busy = 0, pkt_sent = 0;
  - a new start edge after reset restarts from W = 0.
